// File: rtl/posit_normalize_es3_pkg.sv
// -----------------------------------------------------------------------------
// posit_defines_es3 : shared definitions for the posit<32,3> adder datapath.
//   - widths and constants of the raw serialized sum
//   - value_sum     : unpacked view of the 40-bit raw sum
//   - shift_right() : logical right shift used by the regime builder
// -----------------------------------------------------------------------------
package posit_defines_es3;

    localparam int POSIT_SERIALIZED_WIDTH_SUM_ES3 = 40;
    localparam int POSIT_NBITS_ES3                = 32;
    localparam int POSIT_ES_ES3                   = 3;
    localparam int POSIT_FBITS_ES3                = 28;

    localparam logic signed [8:0] POSIT_MAXPOS_SCALE_ES3 = 9'sd240;
    localparam logic [31:0]       POSIT_NAR_ES3          = 32'h8000_0000;
    localparam logic [30:0]       POSIT_MAXPOS_MAG_ES3   = 31'h7FFF_FFFF;

    typedef struct packed {
        logic              sgn;
        logic signed [8:0] scale;
        logic [27:0]       fraction;
        logic              inf;
        logic              zero;
    } value_sum;

    function automatic logic [63:0] shift_right(input logic [63:0] val,
                                                input logic [5:0]  amt);
        return val >> amt;
    endfunction

endpackage

// File: rtl/posit_normalize_es3_if.sv
// -----------------------------------------------------------------------------
// posit_normalize_es3_if : raw-sum interface between the posit adder (master)
// and the normalizer/encoder (slave).
//   start     : raw sum valid
//   in        : raw sum {sgn, scale[8:0], fraction[27:0], inf, zero}
//   truncated : adder dropped nonzero bits during alignment
//   result    : packed posit<32,3> word
//   inexact   : result differs from the exact raw value
//   done      : result/inexact valid
// -----------------------------------------------------------------------------
interface posit_normalize_es3_if;
    import posit_defines_es3::*;

    logic                                      start;
    logic [POSIT_SERIALIZED_WIDTH_SUM_ES3-1:0] in;
    logic                                      truncated;
    logic [POSIT_NBITS_ES3-1:0]                result;
    logic                                      inexact;
    logic                                      done;

    modport master (output start, in, truncated, input result, inexact, done);
    modport slave  (input start, in, truncated, output result, inexact, done);

endinterface

// File: rtl/posit_normalize_es3_regime.sv
// -----------------------------------------------------------------------------
// posit_regime_build_es3 : combinational body builder.
//   k        : regime value (-32..31)
//   e        : exponent field
//   fraction : fraction without hidden bit
//   body     : regime | e | fraction, left-aligned in 64 bits
// k >= 0 : (k+1) ones then a zero; k < 0 : (-k) zeros then a one.
// -----------------------------------------------------------------------------
module posit_regime_build_es3
    import posit_defines_es3::*;
(
    input  logic signed [5:0] k,
    input  logic [2:0]        e,
    input  logic [27:0]       fraction,
    output logic [63:0]       body
);

    logic [5:0]  amt;
    logic [63:0] tail;

    always_comb begin
        amt  = '0;
        tail = '0;
        body = '0;
        if (!k[5]) begin
            amt  = {1'b0, k[4:0]} + 6'd1;
            tail = {1'b0, e, fraction, 32'd0};
        end else begin
            amt  = ~k + 6'd1;
            tail = {1'b1, e, fraction, 32'd0};
        end
        // A 32-place regime already pushes the payload to the bottom word;
        // anything longer is only reachable through the saturation flags.
        if (amt > 6'd32) begin
            amt = 6'd32;
        end
        body = shift_right(tail, amt);
        if (!k[5]) begin
            body = body | ~shift_right({64{1'b1}}, amt);
        end
    end

endmodule

// File: rtl/posit_normalize_es3.sv
// -----------------------------------------------------------------------------
// posit_normalize_es3 : raw posit sum -> packed posit<32,3>, round to nearest
// even with saturation. One result per cycle, start sampled at edge E0 gives
// done after edge E3.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : posit_normalize_es3_if slave (start/in/truncated in,
//                result/inexact/done out)
// Build option POSIT_NORM_TRUNC_STICKY_EN: the truncated input joins the
// sticky bit (rounding and inexact). Without it the input is ignored.
// -----------------------------------------------------------------------------
module posit_normalize_es3
    import posit_defines_es3::*;
#(
    parameter int NBITS = 32,
    parameter int ES    = 3,
    parameter int FBITS = 28
) (
    input  logic                  clk,
    input  logic                  rst_n,
    posit_normalize_es3_if.slave  bus
);

    value_sum in_val;
    assign in_val = bus.in;

    logic trunc_sticky;

    // Input register
    logic     r0_valid;
    value_sum r0_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_valid <= 1'b0;
            r0_val   <= '0;
        end else begin
            // An unknown start takes the else branch and reads as idle.
            if (bus.start) r0_valid <= 1'b1;
            else           r0_valid <= 1'b0;
            r0_val <= in_val;
        end
    end

`ifdef POSIT_NORM_TRUNC_STICKY_EN
    logic r0_trunc;
    logic s1_trunc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_trunc <= 1'b0;
            s1_trunc <= 1'b0;
        end else begin
            r0_trunc <= bus.truncated;
            s1_trunc <= r0_trunc;
        end
    end
    assign trunc_sticky = s1_trunc;
`else
    logic unused_truncated;
    assign unused_truncated = bus.truncated;
    assign trunc_sticky     = 1'b0;
`endif

    // Stage 1: split scale into regime/exponent, flag saturation
    logic signed [8:0] r0_scale;
    assign r0_scale = r0_val.scale;

    logic              s1_valid, s1_sgn, s1_sat_hi, s1_sat_lo, s1_inf, s1_zero;
    logic signed [5:0] s1_k;
    logic [2:0]        s1_e;
    logic [27:0]       s1_frac;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sgn    <= 1'b0;
            s1_k      <= '0;
            s1_e      <= '0;
            s1_frac   <= '0;
            s1_sat_hi <= 1'b0;
            s1_sat_lo <= 1'b0;
            s1_inf    <= 1'b0;
            s1_zero   <= 1'b0;
        end else begin
            s1_valid  <= r0_valid;
            s1_sgn    <= r0_val.sgn;
            // scale >>> 3 always fits in 6 bits: it is just the top slice.
            s1_k      <= r0_scale[8:3];
            s1_e      <= r0_scale[2:0];
            s1_frac   <= r0_val.fraction;
            s1_sat_hi <= (r0_scale >= POSIT_MAXPOS_SCALE_ES3);
            s1_sat_lo <= (r0_scale < -POSIT_MAXPOS_SCALE_ES3);
            s1_inf    <= r0_val.inf;
            s1_zero   <= r0_val.zero;
        end
    end

    // Stage 2: assemble body, extract magnitude/guard/sticky
    logic [63:0] body;

    posit_regime_build_es3 u_regime (
        .k        (s1_k),
        .e        (s1_e),
        .fraction (s1_frac),
        .body     (body)
    );

    logic        s2_valid, s2_sgn, s2_guard, s2_sticky;
    logic        s2_sat_hi, s2_sat_lo, s2_inf, s2_zero;
    logic [30:0] s2_mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_sgn    <= 1'b0;
            s2_mag    <= '0;
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
            s2_sat_hi <= 1'b0;
            s2_sat_lo <= 1'b0;
            s2_inf    <= 1'b0;
            s2_zero   <= 1'b0;
        end else begin
            s2_valid  <= s1_valid;
            s2_sgn    <= s1_sgn;
            s2_mag    <= body[63:33];
            s2_guard  <= body[32];
            s2_sticky <= (|body[31:0]) | trunc_sticky;
            s2_sat_hi <= s1_sat_hi;
            s2_sat_lo <= s1_sat_lo;
            s2_inf    <= s1_inf;
            s2_zero   <= s1_zero;
        end
    end

    // Stage 3: round, saturate, apply sign and specials
    logic [30:0] mag_rnd;
    logic [31:0] result_nxt;
    logic        inexact_nxt;

    always_comb begin
        mag_rnd     = s2_mag;
        result_nxt  = '0;
        inexact_nxt = 1'b0;
        // Incrementing maxpos would wrap into NaR, so it is held.
        if (s2_guard && (s2_sticky || s2_mag[0]) &&
            (s2_mag != POSIT_MAXPOS_MAG_ES3)) begin
            mag_rnd = s2_mag + 31'd1;
        end
        if (s2_sat_hi)      mag_rnd = POSIT_MAXPOS_MAG_ES3;
        else if (s2_sat_lo) mag_rnd = 31'd1;
        result_nxt  = s2_sgn ? (32'd0 - {1'b0, mag_rnd}) : {1'b0, mag_rnd};
        inexact_nxt = s2_guard | s2_sticky | s2_sat_hi | s2_sat_lo;
        if (s2_inf) begin
            result_nxt  = POSIT_NAR_ES3;
            inexact_nxt = 1'b0;
        end else if (s2_zero) begin
            result_nxt  = '0;
            inexact_nxt = 1'b0;
        end
    end

    logic        done_q, inexact_q;
    logic [31:0] result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q    <= 1'b0;
            result_q  <= '0;
            inexact_q <= 1'b0;
        end else begin
            done_q    <= s2_valid;
            result_q  <= result_nxt;
            inexact_q <= inexact_nxt;
        end
    end

    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.inexact = inexact_q;

    // Encoding above is hard-wired for posit<32,3> with a 28-bit fraction.
    always_comb begin
        assert (NBITS == 32 && ES == 3 && FBITS == 28);
    end

endmodule
